pellet_tracker: RTL and testbench

- Upstream of the game-over/collision stage; owns the pellet map and produces the `Not_ate` vector that stage consumes.
- Once per frame, on a frame tick, it scans every pellet position from an external position ROM. Any still-present pellet whose box overlaps Pac-Man's box is cleared.
- Also maintains the score and the remaining-pellet count, and emits per-eat and end-of-scan pulses.

---
 rtl/pellet_tracker_if.sv | 11 +
 rtl/pellet_tracker.sv | 184 ++++++++++++++++++
 tb/tb_pellet_tracker.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pellet_tracker_if.sv
// Pellet position ROM bus: the tracker drives the index, the ROM answers with a pellet centre.
// Latency: Rom_X/Rom_Y belong to the Rom_addr presented one Clk earlier (registered ROM read).
// Backpressure: none; the ROM must answer every cycle, and the tracker issues one address per Clk.
interface pellet_tracker_if;
  logic [7:0] Rom_addr;
  logic [9:0] Rom_X;
  logic [9:0] Rom_Y;

  modport master (output Rom_addr, input Rom_X, input Rom_Y);
  modport slave  (input Rom_addr, output Rom_X, output Rom_Y);
endinterface

// File: rtl/pellet_tracker.sv
// Pellet map owner: once per frame, scans every pellet and clears the ones Pac-Man's box overlaps.
// Latency: the scan occupies NUM_PELLETS+1 Clk after the frame edge, then a one-Clk DONE; Eat_pulse trails its compare by 1 Clk.
// Backpressure: none; frame edges that arrive while a scan is in progress are dropped, not queued.
module pellet_tracker #(
  parameter int NUM_PELLETS = 241,
  parameter int PELLET_SIZE = 2,
  parameter int POINTS      = 10
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic                   Restart,
  input  logic [9:0]             X_pac,
  input  logic [9:0]             Y_pac,
  input  logic [9:0]             Size_pac,
  pellet_tracker_if.master       rom,
  output logic [NUM_PELLETS-1:0] Not_ate,
  output logic [15:0]            Score,
  output logic [8:0]             Remaining,
  output logic                   Busy,
  output logic                   Eat_pulse,
  output logic                   Scan_done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [7:0] LAST_ADDR = 8'(NUM_PELLETS - 1);
  // scan_cnt reaches this value in the cycle that compares the last pellet
  localparam logic [8:0] LAST_CNT  = 9'(NUM_PELLETS);
  localparam logic [8:0] FULL_CNT  = 9'(NUM_PELLETS);
  localparam logic [9:0] PEL_SZ    = 10'(PELLET_SIZE);

  state_t                 state_q, state_d;
  logic                   frame_clk_q, frame_clk_d;
  logic [9:0]             x_snap_q, x_snap_d;
  logic [9:0]             y_snap_q, y_snap_d;
  logic [9:0]             size_snap_q, size_snap_d;
  logic [7:0]             rom_addr_q, rom_addr_d;
  logic [8:0]             scan_cnt_q, scan_cnt_d;
  logic [NUM_PELLETS-1:0] not_ate_q, not_ate_d;
  logic [15:0]            score_q, score_d;
  logic [8:0]             remaining_q, remaining_d;
  logic                   busy_q, busy_d;
  logic                   eat_pulse_q, eat_pulse_d;
  logic                   scan_done_q, scan_done_d;

  logic                   edge_det;
  logic [9:0]             pac_left, pac_right, pac_top, pac_bottom;
  logic [9:0]             pel_left, pel_right, pel_top, pel_bottom;
  logic                   overlap;
  logic [7:0]             cmp_idx;
  logic                   eat;
  logic [16:0]            score_sum;

  // Box geometry and eat decision for the pellet whose ROM data is on the bus this cycle
  always_comb begin
    edge_det   = frame_clk & ~frame_clk_q;
    // 10-bit wrapping arithmetic, identical to the collision stage downstream
    pac_left   = x_snap_q - size_snap_q;
    pac_right  = x_snap_q + size_snap_q;
    pac_top    = y_snap_q - size_snap_q;
    pac_bottom = y_snap_q + size_snap_q;
    pel_left   = rom.Rom_X - PEL_SZ;
    pel_right  = rom.Rom_X + PEL_SZ;
    pel_top    = rom.Rom_Y - PEL_SZ;
    pel_bottom = rom.Rom_Y + PEL_SZ;
    overlap    = !((pac_left > pel_right) || (pac_top > pel_bottom) ||
                   (pac_right < pel_left) || (pac_bottom < pel_top));
    // scan_cnt counts SCAN cycles; ROM data lags the address by one, so it names pellet cnt-1
    cmp_idx    = 8'(scan_cnt_q - 9'd1);
    eat        = (state_q == SCAN) && (scan_cnt_q != 9'd0) && overlap &&
                 not_ate_q[cmp_idx] && (remaining_q != 9'd0);
    score_sum  = {1'b0, score_q} + 17'(POINTS);
  end

  // Next-state and next-output computation for the scan FSM; Restart overrides everything
  always_comb begin
    state_d     = state_q;
    frame_clk_d = frame_clk;
    x_snap_d    = x_snap_q;
    y_snap_d    = y_snap_q;
    size_snap_d = size_snap_q;
    rom_addr_d  = rom_addr_q;
    scan_cnt_d  = scan_cnt_q;
    not_ate_d   = not_ate_q;
    score_d     = score_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    eat_pulse_d = 1'b0;
    scan_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (edge_det) begin
          x_snap_d    = X_pac;
          y_snap_d    = Y_pac;
          size_snap_d = Size_pac;
          rom_addr_d  = 8'd0;
          scan_cnt_d  = 9'd0;
          busy_d      = 1'b1;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (rom_addr_q < LAST_ADDR) begin
          rom_addr_d = rom_addr_q + 8'd1;
        end
        scan_cnt_d = scan_cnt_q + 9'd1;
        if (eat) begin
          not_ate_d[cmp_idx] = 1'b0;
          remaining_d        = remaining_q - 9'd1;
          score_d            = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          eat_pulse_d        = 1'b1;
        end
        if (scan_cnt_q == LAST_CNT) begin
          busy_d      = 1'b0;
          scan_done_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        rom_addr_d = 8'd0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (Restart) begin
      state_d     = IDLE;
      rom_addr_d  = 8'd0;
      scan_cnt_d  = 9'd0;
      not_ate_d   = '1;
      score_d     = 16'd0;
      remaining_d = FULL_CNT;
      busy_d      = 1'b0;
      eat_pulse_d = 1'b0;
      scan_done_d = 1'b0;
    end
  end

  // State and output registers with asynchronous active-high reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      frame_clk_q <= 1'b0;
      x_snap_q    <= 10'd0;
      y_snap_q    <= 10'd0;
      size_snap_q <= 10'd0;
      rom_addr_q  <= 8'd0;
      scan_cnt_q  <= 9'd0;
      not_ate_q   <= '1;
      score_q     <= 16'd0;
      remaining_q <= FULL_CNT;
      busy_q      <= 1'b0;
      eat_pulse_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_clk_q <= frame_clk_d;
      x_snap_q    <= x_snap_d;
      y_snap_q    <= y_snap_d;
      size_snap_q <= size_snap_d;
      rom_addr_q  <= rom_addr_d;
      scan_cnt_q  <= scan_cnt_d;
      not_ate_q   <= not_ate_d;
      score_q     <= score_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      eat_pulse_q <= eat_pulse_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign rom.Rom_addr = rom_addr_q;
  assign Not_ate      = not_ate_q;
  assign Score        = score_q;
  assign Remaining    = remaining_q;
  assign Busy         = busy_q;
  assign Eat_pulse    = eat_pulse_q;
  assign Scan_done    = scan_done_q;

endmodule

// File: tb/tb_pellet_tracker.sv
// Bench for pellet_tracker: registered ROM model plus a per-scan reference of the pellet map.
// Latency: each scan is observed from the frame edge until three cycles after Scan_done.
// Backpressure: none; mid-scan frame edges and position changes are injected to confirm they are ignored.
module tb_pellet_tracker;
  localparam int N = 241;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          frame_clk;
  logic          Restart;
  logic [9:0]    X_pac, Y_pac, Size_pac;
  logic [N-1:0]  Not_ate;
  logic [15:0]   Score;
  logic [8:0]    Remaining;
  logic          Busy, Eat_pulse, Scan_done;

  pellet_tracker_if rom_if ();

  logic [9:0] tab_x [256];
  logic [9:0] tab_y [256];

  logic [N-1:0] m_na;
  int           m_score;
  int           m_rem;
  logic [N-1:0] ones_v = '1;

  int checks = 0;
  int errors = 0;

  pellet_tracker dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .Restart   (Restart),
    .X_pac     (X_pac),
    .Y_pac     (Y_pac),
    .Size_pac  (Size_pac),
    .rom       (rom_if),
    .Not_ate   (Not_ate),
    .Score     (Score),
    .Remaining (Remaining),
    .Busy      (Busy),
    .Eat_pulse (Eat_pulse),
    .Scan_done (Scan_done)
  );

  always #5 Clk = ~Clk;

  // Position ROM with a registered read: data answers the address of the previous cycle
  always @(posedge Clk) begin
    rom_if.Rom_X <= tab_x[rom_if.Rom_addr];
    rom_if.Rom_Y <= tab_y[rom_if.Rom_addr];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Two closed intervals intersect when each one starts no later than the other ends
  function automatic bit hits(input logic [9:0] px, input logic [9:0] py, input logic [9:0] ps,
                              input logic [9:0] ex, input logic [9:0] ey);
    logic [9:0] pl, pr, pt, pb, el, er, et, eb;
    pl = px - ps;  pr = px + ps;  pt = py - ps;  pb = py + ps;
    el = ex - 10'd2; er = ex + 10'd2; et = ey - 10'd2; eb = ey + 10'd2;
    return (pl <= er) && (el <= pr) && (pt <= eb) && (et <= pb);
  endfunction

  task automatic model_scan(output int eats);
    eats = 0;
    for (int i = 0; i < N; i++) begin
      if (m_na[i] && hits(X_pac, Y_pac, Size_pac, tab_x[i], tab_y[i])) begin
        m_na[i] = 1'b0;
        m_rem--;
        m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        eats++;
      end
    end
  endtask

  task automatic model_restart();
    m_na    = '1;
    m_score = 0;
    m_rem   = N;
  endtask

  task automatic run_scan(input string tag, input int mid_edge, input int mid_y_cyc,
                          input logic [9:0] mid_y);
    int eats_exp;
    int busy_n  = 0;
    int eat_n   = 0;
    int done_n  = 0;
    int done_at = -1;
    model_scan(eats_exp);
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      busy_n += int'(Busy);
      eat_n  += int'(Eat_pulse);
      if (Scan_done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (c == 0) frame_clk = 1'b0;
      if (c == mid_edge) frame_clk = 1'b1;
      if (c == mid_edge + 2) frame_clk = 1'b0;
      if (c == mid_y_cyc) Y_pac = mid_y;
      if (done_at >= 0 && c == done_at + 3) break;
    end
    frame_clk = 1'b0;
    chk($sformatf("%s/busy_cycles", tag), 256'(busy_n), 256'(N + 1));
    chk($sformatf("%s/scan_done_pulses", tag), 256'(done_n), 256'd1);
    chk($sformatf("%s/eat_pulses", tag), 256'(eat_n), 256'(eats_exp));
    chk($sformatf("%s/not_ate", tag), 256'(Not_ate), 256'(m_na));
    chk($sformatf("%s/score", tag), 256'(Score), 256'(m_score));
    chk($sformatf("%s/remaining", tag), 256'(Remaining), 256'(m_rem));
    chk($sformatf("%s/busy_after", tag), 256'(Busy), 256'd0);
  endtask

  task automatic start_and_wait(input int cycles);
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (cycles) @(negedge Clk);
  endtask

  task automatic chk_cleared(input string tag);
    chk($sformatf("%s/not_ate", tag), 256'(Not_ate), 256'(ones_v));
    chk($sformatf("%s/score", tag), 256'(Score), 256'd0);
    chk($sformatf("%s/remaining", tag), 256'(Remaining), 256'(N));
    chk($sformatf("%s/busy", tag), 256'(Busy), 256'd0);
  endtask

  initial begin
    int done_n;
    int j;
    Reset = 1'b1; frame_clk = 1'b0; Restart = 1'b0;
    X_pac = 10'd400; Y_pac = 10'd400; Size_pac = 10'd8;
    for (int i = 0; i < 256; i++) begin
      tab_x[i] = 10'(200 + $urandom_range(0, 180));
      tab_y[i] = 10'(20 + $urandom_range(0, 440));
    end
    tab_x[0] = 10'd100; tab_y[0] = 10'd100;
    model_restart();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk_cleared("reset");
    chk("reset/rom_addr", 256'(rom_if.Rom_addr), 256'd0);
    chk("reset/eat_pulse", 256'(Eat_pulse), 256'd0);
    chk("reset/scan_done", 256'(Scan_done), 256'd0);

    // Pac-Man far from every pellet
    run_scan("far", -1, -1, 10'd0);
    chk("far/score_const", 256'(Score), 256'd0);

    // Pac-Man on pellet 0, then a repeat frame at the same spot
    X_pac = 10'd100; Y_pac = 10'd100; Size_pac = 10'd8;
    run_scan("eat0", -1, -1, 10'd0);
    chk("eat0/score_const", 256'(Score), 256'd10);
    chk("eat0/bit0", 256'(Not_ate[0]), 256'd0);
    run_scan("repeat", -1, -1, 10'd0);
    chk("repeat/score_const", 256'(Score), 256'd10);

    // Shared edge pixel overlaps; one pixel further does not
    tab_x[1] = 10'd100; tab_y[1] = 10'd300;
    X_pac = 10'd110; Y_pac = 10'd300;
    run_scan("touch", -1, -1, 10'd0);
    chk("touch/bit1", 256'(Not_ate[1]), 256'd0);
    tab_x[2] = 10'd100; tab_y[2] = 10'd200;
    X_pac = 10'd111; Y_pac = 10'd200;
    run_scan("gap", -1, -1, 10'd0);
    chk("gap/bit2", 256'(Not_ate[2]), 256'd1);

    // Second edge and Y change mid-scan: the snapshot position must win
    tab_x[3] = 10'd50; tab_y[3] = 10'd50;
    tab_x[4] = 10'd50; tab_y[4] = 10'd400;
    X_pac = 10'd50; Y_pac = 10'd50; Size_pac = 10'd4;
    run_scan("snap", 100, 1, 10'd400);
    chk("snap/bit3", 256'(Not_ate[3]), 256'd0);
    chk("snap/bit4", 256'(Not_ate[4]), 256'd1);

    // Pac-Man box wrapping below zero
    tab_x[5] = 10'd3; tab_y[5] = 10'd3;
    X_pac = 10'd2; Y_pac = 10'd2; Size_pac = 10'd4;
    run_scan("wrap", -1, -1, 10'd0);
    chk("wrap/bit5", 256'(Not_ate[5]), 256'd1);

    // Random positions near random pellets, with random mid-scan disturbances
    for (int r = 0; r < 6; r++) begin
      j = $urandom_range(6, N - 1);
      X_pac = tab_x[j] + 10'($urandom_range(0, 20)) - 10'd10;
      Y_pac = tab_y[j] + 10'($urandom_range(0, 20)) - 10'd10;
      Size_pac = 10'($urandom_range(0, 12));
      run_scan($sformatf("rand%0d", r), $urandom_range(5, 230), $urandom_range(1, 200),
               10'($urandom_range(0, 1023)));
    end

    // Restart from idle
    @(negedge Clk); Restart = 1'b1;
    @(negedge Clk); Restart = 1'b0;
    model_restart();
    chk_cleared("restart_idle");

    // Restart mid-scan after pellets 0..4 are eaten
    for (int i = 0; i < 256; i++) begin
      tab_x[i] = 10'(700 + $urandom_range(0, 200));
      tab_y[i] = 10'(700 + $urandom_range(0, 200));
    end
    for (int i = 0; i < 5; i++) begin
      tab_x[i] = 10'd200; tab_y[i] = 10'd200;
    end
    X_pac = 10'd200; Y_pac = 10'd200; Size_pac = 10'd3;
    start_and_wait(20);
    chk("mid/score", 256'(Score), 256'd50);
    chk("mid/remaining", 256'(Remaining), 256'd236);
    chk("mid/busy", 256'(Busy), 256'd1);
    Restart = 1'b1;
    @(negedge Clk); Restart = 1'b0;
    chk_cleared("restart_mid");
    done_n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge Clk);
      done_n += int'(Scan_done) + int'(Busy);
    end
    chk("restart_mid/no_resume", 256'(done_n), 256'd0);

    // Asynchronous Reset mid-scan takes effect without a clock edge
    start_and_wait(20);
    chk("mid2/score", 256'(Score), 256'd50);
    #2 Reset = 1'b1;
    #1;
    chk_cleared("reset_mid");
    @(negedge Clk); Reset = 1'b0;
    done_n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge Clk);
      done_n += int'(Scan_done) + int'(Busy);
    end
    chk("reset_mid/no_resume", 256'(done_n), 256'd0);
    model_restart();

    // Every pellet under Pac-Man: the whole map is eaten in one scan
    for (int i = 0; i < 256; i++) begin
      tab_x[i] = 10'd300; tab_y[i] = 10'd300;
    end
    X_pac = 10'd300; Y_pac = 10'd300; Size_pac = 10'd0;
    run_scan("all", -1, -1, 10'd0);
    chk("all/score_const", 256'(Score), 256'd2410);
    chk("all/remaining_const", 256'(Remaining), 256'd0);
    chk("all/not_ate_const", 256'(Not_ate), 256'd0);
    run_scan("after_all", -1, -1, 10'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
